// File: rtl/rv32_pkg.sv
`default_nettype none
// rv32_pkg: opcode/funct3 constants and MEM-stage FSM state type shared by the RV32 MEM stage.
// Revision 1.0
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32_load_align.sv
`default_nettype none
// rv32_load_align: selects the addressed byte/half of a read word and sign- or zero-extends it.
// Revision 1.0
module rv32_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: w_byte = rdata_i[7:0];
      2'd1: w_byte = rdata_i[15:8];
      2'd2: w_byte = rdata_i[23:16];
      2'd3: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_B:    result_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   result_o = {24'd0, w_byte};
      F3_H:    result_o = {{16{w_half[15]}}, w_half};
      F3_HU:   result_o = {16'd0, w_half};
      default: result_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32_mem_stage.sv
`default_nettype none
// rv32_mem_stage: RV32 MEM stage driving a req/gnt/rvalid data port and stalling while busy.
// Optional RV32_MEM_TIMEOUT_EN adds a gnt/rvalid watchdog with bus_err_out. Revision 1.0
module rv32_mem_stage
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] code_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] data_res_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_load, w_is_store, w_misalign, w_go, w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_aligned;
  logic        w_unused_code;

  mem_state_t  state_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [3:0]  be_q;
  logic        we_q, misalign_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  assign w_opcode      = code_in[6:0];
  assign w_funct3      = code_in[14:12];
  assign w_unused_code = ^{code_in[31:15], code_in[11:7]};

  assign w_is_load  = (w_opcode == OPC_LOAD) && (w_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign w_is_store = (w_opcode == OPC_STORE) && (w_funct3 inside {F3_B, F3_H, F3_W});
  // funct3[1:0] encodes access size for both loads and stores: 01 = half, 10 = word
  assign w_misalign = ((w_funct3[1:0] == 2'b01) && alu_res_in[0]) ||
                      ((w_funct3[1:0] == 2'b10) && (alu_res_in[1:0] != 2'b00));
  assign w_go  = (w_is_load || w_is_store) && !w_misalign;
  assign w_bad = (w_is_load || w_is_store) && w_misalign;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_in;
    case (w_funct3)
      F3_B: begin
        w_be    = 4'b0001 << alu_res_in[1:0];
        w_wdata = {4{store_data_in[7:0]}};
      end
      F3_H: begin
        w_be    = alu_res_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
      end
    endcase
  end

  rv32_load_align u_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .result_o  (w_aligned)
  );

`ifdef RV32_MEM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        bus_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
`ifdef RV32_MEM_TIMEOUT_EN
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      misalign_q <= 1'b0;
`ifdef RV32_MEM_TIMEOUT_EN
      bus_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (w_go) begin
            state_q   <= REQ;
            addr_q    <= {alu_res_in[31:2], 2'b00};
            we_q      <= w_is_store;
            be_q      <= w_is_store ? w_be : 4'b1111;
            wdata_q   <= w_is_store ? w_wdata : 32'd0;
            funct3_q  <= w_funct3;
            addr_lo_q <= alu_res_in[1:0];
`ifdef RV32_MEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end else if (w_bad) begin
            misalign_q <= 1'b1;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            state_q <= we_q ? DONE : WAIT;
`ifdef RV32_MEM_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q   <= DONE;
            bus_err_q <= 1'b1;
            if (!we_q) data_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            data_q  <= w_aligned;
            state_q <= DONE;
`ifdef RV32_MEM_TIMEOUT_EN
          end else if (cnt_q == TO_LAST) begin
            state_q   <= DONE;
            bus_err_q <= 1'b1;
            data_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign data_res_out = data_q;
  assign misalign_out = misalign_q;
  assign stall_out    = ((state_q == IDLE) && w_go) || (state_q == REQ) || (state_q == WAIT);

`ifdef RV32_MEM_TIMEOUT_EN
  assign bus_err_out = bus_err_q;
`else
  assign bus_err_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_stage.sv
`default_nettype none
// tb_rv32_mem_stage: directed self-checking bench for the RV32 MEM stage.
module tb_rv32_mem_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW  = 32'h0000_2003;
  localparam logic [31:0] SH  = 32'h0000_1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] code_in, alu_res_in, store_data_in, dmem_rdata;
  logic        dmem_gnt, dmem_rvalid;
  logic        dmem_req, dmem_we, stall_out, misalign_out, bus_err_out;
  logic [31:0] dmem_addr, dmem_wdata, data_res_out;
  logic [3:0]  dmem_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_mem_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .alu_res_in(alu_res_in),
    .store_data_in(store_data_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .data_res_out(data_res_out), .stall_out(stall_out), .misalign_out(misalign_out),
    .bus_err_out(bus_err_out)
  );

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; code_in = NOP; alu_res_in = '0; store_data_in = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    mid();
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    n_cmp++; if (data_res_out !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_res_out); end
    n_cmp++; if (misalign_out !== 1'b0 || bus_err_out !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got %b%b want 00", misalign_out, bus_err_out); end
    next_cyc(); rst_n = 1'b1; next_cyc();
  endtask

  task automatic test_lw_basic();
    code_in = LW; alu_res_in = 32'h100;
    mid();
    n_cmp++; if (stall_out !== 1'b1 || dmem_req !== 1'b0) begin n_err++; $display("FAIL lw_idle: got stall=%b req=%b want 1/0", stall_out, dmem_req); end
    next_cyc(); dmem_gnt = 1'b1;
    mid();
    n_cmp++; if ({dmem_req, dmem_we, dmem_be, stall_out} !== 7'b1_0_1111_1 || dmem_addr !== 32'h100) begin
      n_err++; $display("FAIL lw_req: got req=%b we=%b be=%b stall=%b addr=%h want 1/0/1111/1/100", dmem_req, dmem_we, dmem_be, stall_out, dmem_addr); end
    next_cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    mid();
    n_cmp++; if (stall_out !== 1'b1 || dmem_req !== 1'b0) begin n_err++; $display("FAIL lw_wait: got stall=%b req=%b want 1/0", stall_out, dmem_req); end
    next_cyc(); dmem_rvalid = 1'b0;
    mid();
    n_cmp++; if (stall_out !== 1'b0 || data_res_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_done: got stall=%b data=%h want 0/deadbeef", stall_out, data_res_out); end
    next_cyc(); code_in = NOP;
  endtask

  task automatic test_load_ext();
    logic [31:0] codes [4] = '{32'h0000_0003, 32'h0000_4003, 32'h0000_1003, 32'h0000_5003};
    logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233};
    for (int i = 0; i < 4; i++) begin
      code_in = codes[i]; alu_res_in = addrs[i];
      next_cyc(); dmem_gnt = 1'b1;
      mid();
      n_cmp++; if (dmem_addr !== 32'h100) begin n_err++; $display("FAIL load_ext_addr[%0d]: got %h want 00000100", i, dmem_addr); end
      next_cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80112233;
      next_cyc(); dmem_rvalid = 1'b0;
      mid();
      n_cmp++; if (data_res_out !== exps[i]) begin n_err++; $display("FAIL load_ext[%0d]: got %h want %h", i, data_res_out, exps[i]); end
      next_cyc(); code_in = NOP;
    end
  endtask

  task automatic test_store_hold();
    code_in = SH; alu_res_in = 32'h202; store_data_in = 32'h1234ABCD;
    next_cyc();
    for (int i = 0; i < 5; i++) begin
      mid();
      n_cmp++; if ({dmem_req, dmem_we, dmem_be, stall_out} !== 7'b1_1_1100_1 || dmem_wdata !== 32'hABCDABCD || dmem_addr !== 32'h200) begin
        n_err++; $display("FAIL sh_hold[%0d]: got req=%b we=%b be=%b stall=%b wd=%h addr=%h want 1/1/1100/1/abcdabcd/200",
                          i, dmem_req, dmem_we, dmem_be, stall_out, dmem_wdata, dmem_addr); end
      next_cyc();
    end
    dmem_gnt = 1'b1;
    next_cyc(); dmem_gnt = 1'b0;
    mid();
    n_cmp++; if (stall_out !== 1'b0 || dmem_req !== 1'b0 || data_res_out !== 32'h2233) begin
      n_err++; $display("FAIL sh_done: got stall=%b req=%b data=%h want 0/0/00002233", stall_out, dmem_req, data_res_out); end
    next_cyc(); code_in = NOP;
  endtask

  task automatic test_store_lanes();
    logic [31:0] codes [2] = '{32'h0000_0023, 32'h0000_2023};
    logic [31:0] addrs [2] = '{32'h301, 32'h404};
    logic [31:0] rs2s  [2] = '{32'h1122_335A, 32'hCAFE_F00D};
    logic [3:0]  bes   [2] = '{4'b0010, 4'b1111};
    logic [31:0] wds   [2] = '{32'h5A5A_5A5A, 32'hCAFE_F00D};
    logic [31:0] was   [2] = '{32'h300, 32'h404};
    for (int i = 0; i < 2; i++) begin
      code_in = codes[i]; alu_res_in = addrs[i]; store_data_in = rs2s[i];
      next_cyc(); dmem_gnt = 1'b1;
      mid();
      n_cmp++; if (dmem_be !== bes[i] || dmem_wdata !== wds[i] || dmem_we !== 1'b1 || dmem_addr !== was[i]) begin
        n_err++; $display("FAIL store_lane[%0d]: got be=%b wd=%h we=%b addr=%h want %b/%h/1/%h", i, dmem_be, dmem_wdata, dmem_we, dmem_addr, bes[i], wds[i], was[i]); end
      next_cyc(); dmem_gnt = 1'b0;
      mid();
      n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL store_done[%0d]: got stall=%b want 0", i, stall_out); end
      next_cyc(); code_in = NOP;
    end
  endtask

  task automatic test_misalign();
    logic [31:0] codes [2] = '{LW, SH};
    logic [31:0] addrs [2] = '{32'h101, 32'h203};
    for (int i = 0; i < 2; i++) begin
      code_in = codes[i]; alu_res_in = addrs[i]; store_data_in = 32'hFFFF_FFFF;
      mid();
      n_cmp++; if (stall_out !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_idle[%0d]: got stall=%b req=%b want 0/0", i, stall_out, dmem_req); end
      next_cyc(); code_in = NOP;
      mid();
      n_cmp++; if (misalign_out !== 1'b1 || dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_pulse[%0d]: got mis=%b req=%b want 1/0", i, misalign_out, dmem_req); end
      next_cyc();
      mid();
      n_cmp++; if (misalign_out !== 1'b0 || data_res_out !== 32'h2233) begin n_err++; $display("FAIL mis_after[%0d]: got mis=%b data=%h want 0/00002233", i, misalign_out, data_res_out); end
      next_cyc();
    end
    code_in = 32'h0000_3003; alu_res_in = 32'h100;
    mid();
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL illegal_f3: got stall=%b want 0", stall_out); end
    next_cyc(); code_in = NOP; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    next_cyc(); dmem_rvalid = 1'b0;
    mid();
    n_cmp++; if (misalign_out !== 1'b0 || data_res_out !== 32'h2233) begin n_err++; $display("FAIL stray_rvalid: got mis=%b data=%h want 0/00002233", misalign_out, data_res_out); end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    code_in = LW; alu_res_in = 32'h100;
    next_cyc(); dmem_gnt = 1'b1;
    next_cyc(); dmem_gnt = 1'b0;
    mid();
    rst_n = 1'b0; #1;
    n_cmp++; if (dmem_req !== 1'b0 || data_res_out !== 32'h0) begin n_err++; $display("FAIL rst_mid: got req=%b data=%h want 0/0", dmem_req, data_res_out); end
    code_in = NOP; #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got stall=%b want 0", stall_out); end
    next_cyc(); rst_n = 1'b1; next_cyc();
    code_in = LW; alu_res_in = 32'h500;
    next_cyc(); dmem_gnt = 1'b1;
    next_cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    next_cyc(); dmem_rvalid = 1'b0;
    mid();
    n_cmp++; if (data_res_out !== 32'h0BADF00D || stall_out !== 1'b0) begin n_err++; $display("FAIL rst_after_lw: got data=%h stall=%b want 0badf00d/0", data_res_out, stall_out); end
    next_cyc(); code_in = NOP;
  endtask

  task automatic test_back_to_back();
    code_in = LW; alu_res_in = 32'h10;
    next_cyc(); dmem_gnt = 1'b1;
    next_cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA_55AA;
    next_cyc(); dmem_rvalid = 1'b0;
    mid();
    n_cmp++; if (stall_out !== 1'b0 || data_res_out !== 32'h55AA55AA) begin n_err++; $display("FAIL b2b_lw: got stall=%b data=%h want 0/55aa55aa", stall_out, data_res_out); end
    next_cyc(); code_in = 32'h0000_2023; alu_res_in = 32'h14; store_data_in = 32'h0102_0304;
    mid();
    n_cmp++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got stall=%b want 1", stall_out); end
    next_cyc();
    mid();
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h14) begin n_err++; $display("FAIL b2b_sw: got req=%b we=%b addr=%h want 1/1/00000014", dmem_req, dmem_we, dmem_addr); end
    dmem_gnt = 1'b1;
    next_cyc(); dmem_gnt = 1'b0;
    mid();
    n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL b2b_sw_done: got stall=%b want 0", stall_out); end
    next_cyc(); code_in = NOP;
  endtask

`ifdef RV32_MEM_TIMEOUT_EN
  task automatic test_timeout();
    code_in = LW; alu_res_in = 32'h600;
    next_cyc();
    for (int i = 0; i < 8; i++) begin
      mid();
      n_cmp++; if (dmem_req !== 1'b1 || bus_err_out !== 1'b0) begin n_err++; $display("FAIL to_req[%0d]: got req=%b err=%b want 1/0", i, dmem_req, bus_err_out); end
      next_cyc();
    end
    mid();
    n_cmp++; if (bus_err_out !== 1'b1 || stall_out !== 1'b0 || data_res_out !== 32'h0) begin
      n_err++; $display("FAIL to_done: got err=%b stall=%b data=%h want 1/0/0", bus_err_out, stall_out, data_res_out); end
    next_cyc(); code_in = NOP;
    mid();
    n_cmp++; if (bus_err_out !== 1'b0) begin n_err++; $display("FAIL to_pulse: got err=%b want 0", bus_err_out); end
    next_cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_lw_basic();
    test_load_ext();
    test_store_hold();
    test_store_lanes();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
`ifdef RV32_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32_mem_stage.md
Name: rv32_mem_stage

Overview:
- MEM stage of the RV32 pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Decodes loads and stores from the instruction word, then drives a req/gnt/rvalid data-memory port.
- Aligns and sign-extends load data and produces data_res_out, which the MEM/WB register captures.
- Asserts stall_out to freeze the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for gnt or rvalid. Used only when the optional feature is compiled in. Range 1..65535.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- code_in  in  32  instruction in MEM. opcode = [6:0], funct3 = [14:12].
- alu_res_in  in  32  effective address from EX
- store_data_in  in  32  rs2 value for stores
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address, {alu_res_in[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data, lane-replicated
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- data_res_out  out  32  aligned load result
- stall_out  out  1  hold upstream stages and do not advance MEM/WB
- misalign_out  out  1  one-cycle pulse: misaligned access suppressed
- bus_err_out  out  1  timeout abort pulse (feature only, otherwise tied 0)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Op decode:
  - Load: opcode 0000011 with funct3 000/001/010/100/101 (LB/LH/LW/LBU/LHU).
  - Store: opcode 0100011 with funct3 000/001/010 (SB/SH/SW).
  - Anything else, including illegal funct3: no access, no stall.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued; misalign_out pulses for 1 cycle; stall_out stays 0.
  - A store is dropped; data_res_out is unchanged.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: aligned mem op present -> REQ. stall_out=1 combinationally in this cycle.
  - REQ: dmem_req=1. addr/we/be/wdata stay stable until gnt. Without gnt, stay in REQ. With gnt: a store -> DONE, a load -> WAIT.
  - WAIT: dmem_req=0. On rvalid, capture the aligned data into data_q and go to DONE. rvalid is ignored in any state other than WAIT.
  - DONE: stall_out=0 and the pipeline advances this cycle. Always -> IDLE.
- stall_out = (IDLE & aligned op) | REQ | WAIT.
- The EX/MEM inputs must stay stable while stall_out=1. The block samples op fields only in IDLE.
- Latency with gnt and rvalid on their first eligible cycle:
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE).
  - Store: 3 cycles.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
- Loads: dmem_we=0, dmem_be=1111.
  - Select the byte or half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- data_res_out = data_q (registered). It updates only on load completion and holds otherwise.
- Reset (including mid-transaction):
  - state=IDLE; data_q=0; dmem_req=0 immediately.
  - The memory side must discard any in-flight response.
  - All pulses are 0.
- Back-to-back ops: DONE -> IDLE -> the next op is accepted with no idle bubble beyond IDLE itself.

Optional Feature:
- RV32_MEM_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ or WAIT and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES, go to DONE, pulse bus_err_out, and leave data_q unchanged. For a load, data_q is instead set to 0.
- RV32_MEM_TIMEOUT_EN undefined: no counter; bus_err_out is tied 0; the block waits indefinitely.

Decomposition:
- Shared package rv32_pkg:
  - Opcode constants OPC_LOAD and OPC_STORE.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Enum mem_state_t {IDLE, REQ, WAIT, DONE}.
- Sub-module rv32_load_align: combinational byte/half select plus sign/zero extend, (rdata, addr[1:0], funct3) -> 32-bit result.

Test Plan:
- LW addr 0x100, gnt in cycle 2, rvalid in cycle 3 with 0xDEADBEEF -> stall_out high for 3 cycles; data_res_out=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 -> data_res_out=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x202, rs2=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1; gnt held off 5 cycles -> outputs stable for all 5 cycles, then DONE.
- LW addr 0x101 -> no dmem_req; misalign_out pulses once; stall_out=0.
- rst_n driven low while in WAIT -> dmem_req=0, data_res_out=0, state IDLE; a following LW completes normally.
- With RV32_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt never asserted -> after 8 cycles in REQ: bus_err_out pulses, stall_out drops, data_res_out=0.
